sram_banked_model: RTL and testbench
====================================

// Module: sram_banked_model
// PURPOSE
//  Parametrised, banked behavioural SRAM for memory_core. It generalises the single 512x64 macro model in
//  width, depth and bank count, and adds active-high ports, a configurable read pipeline, a read-valid
//  strobe and reset of the output path. Unit/tile tests use it in place of the hard macros; the
//  active-low macro pins are generated internally per bank.
// PARAMETERS
//  WIDTH         64   data word width, bits (>=1)
//  ADDR_WIDTH    11   total word address width; total depth = 2**ADDR_WIDTH
//  NUM_BANKS     4    power of two, 1..2**ADDR_WIDTH; bank = addr MSBs
//  READ_LATENCY  1    1 or 2 cycles from accepted read to rdata/rd_valid
//  RTSEL_VAL     2'b01 constant driven on every bank RTSEL pin
//  WTSEL_VAL     2'b00 constant driven on every bank WTSEL pin
// PORTS
//  clk       in   1           rising-edge clock
//  rst_n     in   1           asynchronous active-low reset
//  cen       in   1           access enable (active high)
//  wen       in   1           1 = write, 0 = read; ignored when cen=0
//  addr      in   ADDR_WIDTH  word address
//  wdata     in   WIDTH       write data
//  wmask     in   WIDTH       per-bit write enable (active high)
//  rdata     out  WIDTH       read data
//  rd_valid  out  1           one-cycle strobe: rdata carries a new read result
// BEHAVIOUR
//  - Address split: bank = addr[ADDR_WIDTH-1 -: log2(NUM_BANKS)], row = remaining LSBs.
//    NUM_BANKS=1 gives a single bank with row = addr. Only the selected bank sees CEB=0.
//  - Write (cen=1, wen=1): at the edge, row[i] <= wdata[i] for each i with wmask[i]=1; other bits keep
//    their value. wmask=0 is a legal no-op access. rd_valid stays 0; rdata is unchanged.
//  - Read (cen=1, wen=0): the bank captures row contents at the edge and the bank index is registered.
//    With READ_LATENCY=1, rdata and rd_valid=1 appear after that edge (next cycle). With
//    READ_LATENCY=2, one further output register stage follows.
//    Back-to-back reads give one result per cycle, in order.
//  - rdata holds its last read result until the next rd_valid. Idle cycles and writes never change it.
//  - Read-after-write to the same address in the next cycle returns the new data.
//    Only one access per cycle, so no same-cycle read/write conflict exists.
//  - Bank macro Q also updates on writes (old-data semantics). The wrapper masks this with the
//    registered read flag, so writes never appear on rdata.
//  - Reset (rst_n=0, any time): rdata=0, rd_valid=0, pipeline valid bits and registered bank index
//    cleared at once. Reads in flight are dropped and produce no rd_valid after release.
//    Array contents are NOT reset. Accesses with rst_n=0 are ignored.
//  - X on cen is illegal; the bench asserts on it. X on addr/wdata with cen=0 is ignored.
// STRUCTURE
//  - mem_pkg: typedefs mem_word_t, mem_addr_t; constants for default WIDTH/ADDR_WIDTH;
//    function clog2_banks(). Both this block and the bank sub-module import it.
//  - One sub-module sram_bank_macro: a single active-low bank with Q/CLK/CEB/WEB/BWEB/A/D/RTSEL/WTSEL
//    pins and read-before-write Q. It is instantiated NUM_BANKS times in a generate loop.
//  - Top-level logic: polarity inversion, bank decode, registered bank index and valid pipeline
//    (depth READ_LATENCY), output mux and optional second stage, reset of the output path.
// TESTING
//  1 Reset then idle: rst_n low 3 cycles -> rdata=0, rd_valid=0. No rd_valid for 10 idle cycles after release.
//  2 Write then read, LAT=1:
//    - stimulus: write addr=0x005 data=0xDEAD_BEEF_0123_4567 mask=all-1, then read 0x005 next cycle.
//    - response: rd_valid high exactly 1 cycle later, rdata=0xDEAD_BEEF_0123_4567.
//  3 Bit mask:
//    - stimulus: write all-1s to 0x010, write 0 with wmask=0x0000_0000_FFFF_FFFF, read 0x010.
//    - response: rdata=0xFFFF_FFFF_0000_0000.
//  4 Bank crossing and ordering, LAT=2:
//    - stimulus: write i*0x1111 to addr i<<9 for banks 0..3, then back-to-back reads of banks 3,0,2,1.
//    - response: rd_valid 2 cycles after each read; data 0x3333,0x0000,0x2222,0x1111 in order.
//  5 Hold and write transparency: read 0x005, then 4 writes elsewhere -> rdata stays 0xDEAD_BEEF_0123_4567, rd_valid 0.
//  6 Reset mid-read, LAT=2:
//    - stimulus: issue a read, assert rst_n low the next cycle.
//    - response: rdata=0 at once, no rd_valid after release; re-reading 0x005 returns the original data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, default sizes and bank-count helper for the banked SRAM model.
package mem_pkg;

  localparam int unsigned MEM_WIDTH_DEF      = 64;
  localparam int unsigned MEM_ADDR_WIDTH_DEF = 11;

  typedef logic [MEM_WIDTH_DEF-1:0]      mem_word_t;
  typedef logic [MEM_ADDR_WIDTH_DEF-1:0] mem_addr_t;

  // Number of address bits needed to select one of n banks (0 for n <= 1).
  function automatic int unsigned clog2_banks(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_bank_macro.sv
// Behavioural single-bank macro: active-low controls, per-bit write mask, read-before-write Q.
module sram_bank_macro
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH     = MEM_WIDTH_DEF,
  parameter int unsigned ROW_WIDTH = 9
) (
  output logic [WIDTH-1:0]     Q,
  input  logic                 CLK,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [WIDTH-1:0]     BWEB,
  input  logic [ROW_WIDTH-1:0] A,
  input  logic [WIDTH-1:0]     D,
  input  logic [1:0]           RTSEL,
  input  logic [1:0]           WTSEL
);

  logic [WIDTH-1:0] mem [2**ROW_WIDTH];

  // Timing-select pins only tune the real macro's margins; no behavioural effect here.
  logic unused_tsel;
  assign unused_tsel = ^{RTSEL, WTSEL};

  always_ff @(posedge CLK) begin
    if (!CEB) begin
      Q <= mem[A];
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
    end
  end

endmodule

// File: rtl/sram_banked_model.sv
// Banked behavioural SRAM: active-high access port over NUM_BANKS active-low macros,
// with a registered read-valid pipeline and a resettable, holding output path.
module sram_banked_model
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH        = MEM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = MEM_ADDR_WIDTH_DEF,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [1:0]  RTSEL_VAL    = 2'b01,
  parameter logic [1:0]  WTSEL_VAL    = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      wmask,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rd_valid
);

  localparam int unsigned BANK_BITS = clog2_banks(NUM_BANKS);
  localparam int unsigned BIDX_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_W     = (ADDR_WIDTH > BANK_BITS) ? ADDR_WIDTH - BANK_BITS : 1;

  logic [BIDX_W-1:0] bank_sel;
  logic [BIDX_W-1:0] bank_q;
  logic [ROW_W-1:0]  row;
  logic [WIDTH-1:0]  bank_dout [NUM_BANKS];
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  rdata_hold;
  logic              access;
  logic              rd_access;
  logic              rd_v1;

  // Accesses while reset is asserted never reach the macros.
  assign access    = cen && rst_n;
  assign rd_access = access && !wen;

  if (BANK_BITS == 0) begin : g_single_bank
    assign bank_sel = '0;
    assign row      = addr[ROW_W-1:0];
  end else if (ADDR_WIDTH > BANK_BITS) begin : g_split_addr
    assign bank_sel = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign row      = addr[ROW_W-1:0];
  end else begin : g_word_banks
    assign bank_sel = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign row      = '0;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic ceb;
    assign ceb = !(access && (bank_sel == BIDX_W'(b)));

    sram_bank_macro #(
      .WIDTH     (WIDTH),
      .ROW_WIDTH (ROW_W)
    ) u_bank (
      .Q     (bank_dout[b]),
      .CLK   (clk),
      .CEB   (ceb),
      .WEB   (!wen),
      .BWEB  (~wmask),
      .A     (row),
      .D     (wdata),
      .RTSEL (RTSEL_VAL),
      .WTSEL (WTSEL_VAL)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1  <= 1'b0;
      bank_q <= '0;
    end else begin
      rd_v1 <= rd_access;
      if (rd_access) bank_q <= bank_sel;
    end
  end

  // Macro Q also moves on writes; only a registered read flag lets it through.
  assign rd_word = bank_dout[bank_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_hold <= '0;
    else if (rd_v1) rdata_hold <= rd_word;
  end

  // For two-cycle latency the hold register doubles as the second output stage.
  if (READ_LATENCY == 1) begin : g_lat1
    assign rdata    = rd_v1 ? rd_word : rdata_hold;
    assign rd_valid = rd_v1;
  end else begin : g_lat2
    logic rd_v2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_v2 <= 1'b0;
      else        rd_v2 <= rd_v1;
    end
    assign rdata    = rdata_hold;
    assign rd_valid = rd_v2;
  end

endmodule

// File: tb/tb_sram_banked_model.sv
// Self-checking bench: one-cycle and two-cycle latency instances driven in parallel,
// table-driven accesses with a per-instance scoreboard, plus reset sequences.
module tb_sram_banked_model;

  localparam int unsigned W  = 64;
  localparam int unsigned AW = 11;

  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_t;

  typedef struct {
    op_t           op;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  wmask;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
  } sb_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen   = 1'b0;
  logic          wen   = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  wmask = '0;
  logic [W-1:0]  rdata    [2];
  logic          rd_valid [2];

  sb_t          sbq [2][$];
  logic [W-1:0] last [2];
  vec_t         vecs [$];
  int unsigned  cyc    = 0;
  int unsigned  checks = 0;
  int unsigned  errors = 0;

  sram_banked_model #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_BANKS(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wen(wen), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rdata(rdata[0]), .rd_valid(rd_valid[0])
  );

  sram_banked_model #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_BANKS(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wen(wen), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rdata(rdata[1]), .rd_valid(rd_valid[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rst_n) assert (!$isunknown(cen)) else $error("cen is unknown while out of reset");

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_port(input int d, input logic v, input logic [W-1:0] r);
    sb_t it;
    if (!rst_n) begin
      chk($sformatf("lat%0d_reset_valid", d + 1), {63'd0, v}, '0);
      chk($sformatf("lat%0d_reset_rdata", d + 1), r, '0);
    end else if (v === 1'b1) begin
      if (sbq[d].size() == 0) begin
        chk($sformatf("lat%0d_unexpected_valid", d + 1), {63'd0, v}, '0);
      end else begin
        it = sbq[d].pop_front();
        chk($sformatf("lat%0d_rdata", d + 1), r, it.data);
        chk($sformatf("lat%0d_latency", d + 1), W'(cyc), W'(it.due));
        last[d] = it.data;
      end
    end else begin
      chk($sformatf("lat%0d_hold", d + 1), r, last[d]);
      if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
        chk($sformatf("lat%0d_missing_valid", d + 1), {63'd0, v}, W'(1));
        void'(sbq[d].pop_front());
      end else begin
        chk($sformatf("lat%0d_valid_low", d + 1), {63'd0, v}, '0);
      end
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 2; d++) check_port(d, rd_valid[d], rdata[d]);

  function automatic vec_t mk(input op_t op, input logic [AW-1:0] a, input logic [W-1:0] wd,
                              input logic [W-1:0] wm, input logic [W-1:0] ex);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.wmask = wm; v.exp = ex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge clk); #1;
    cen   = (v.op != OP_IDLE);
    wen   = (v.op == OP_WR);
    addr  = v.addr;
    wdata = v.wdata;
    wmask = v.wmask;
    if (v.op == OP_RD) begin
      e.data = v.exp;
      e.due  = cyc + 1; sbq[0].push_back(e);
      e.due  = cyc + 2; sbq[1].push_back(e);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) apply(mk(OP_IDLE, 'x, 'x, '0, '0));
  endtask

  task automatic flush_sb();
    for (int d = 0; d < 2; d++) begin
      sbq[d].delete();
      last[d] = '0;
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    flush_sb();

    // Reset held for three cycles, then ten quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d_por_rdata", d + 1), rdata[d], '0);
      chk($sformatf("lat%0d_por_valid", d + 1), {63'd0, rd_valid[d]}, '0);
    end
    rst_n = 1'b1;
    idle(10);

    vecs.push_back(mk(OP_WR, 11'h005, 64'hDEAD_BEEF_0123_4567, ones, '0));
    vecs.push_back(mk(OP_RD, 11'h005, '0, '0, 64'hDEAD_BEEF_0123_4567));
    vecs.push_back(mk(OP_WR, 11'h010, ones, ones, '0));
    vecs.push_back(mk(OP_WR, 11'h010, '0, 64'h0000_0000_FFFF_FFFF, '0));
    vecs.push_back(mk(OP_RD, 11'h010, '0, '0, 64'hFFFF_FFFF_0000_0000));
    for (int unsigned i = 0; i < 4; i++)
      vecs.push_back(mk(OP_WR, AW'(i << 9), W'(i * 32'h1111), ones, '0));
    vecs.push_back(mk(OP_RD, 11'h600, '0, '0, 64'h3333));
    vecs.push_back(mk(OP_RD, 11'h000, '0, '0, 64'h0000));
    vecs.push_back(mk(OP_RD, 11'h400, '0, '0, 64'h2222));
    vecs.push_back(mk(OP_RD, 11'h200, '0, '0, 64'h1111));
    vecs.push_back(mk(OP_RD, 11'h005, '0, '0, 64'hDEAD_BEEF_0123_4567));
    for (int unsigned i = 0; i < 4; i++)
      vecs.push_back(mk(OP_WR, AW'(11'h100 + i), {32'hA5A5_0000, 32'(i)}, ones, '0));
    vecs.push_back(mk(OP_IDLE, 'x, 'x, '0, '0));
    vecs.push_back(mk(OP_WR, 11'h020, 64'h0123_4567_89AB_CDEF, ones, '0));
    vecs.push_back(mk(OP_WR, 11'h020, ones, '0, '0));
    vecs.push_back(mk(OP_RD, 11'h020, '0, '0, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(OP_RD, 11'h102, '0, '0, 64'hA5A5_0000_0000_0002));
    vecs.push_back(mk(OP_WR, 11'h7FF, 64'h0F0F_0F0F_F0F0_F0F0, 64'h00FF_00FF_00FF_00FF, '0));
    vecs.push_back(mk(OP_WR, 11'h7FE, ones, ones, '0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    idle(4);

    // Reset asserted the cycle after a read is accepted: result must be dropped.
    apply(mk(OP_RD, 11'h005, '0, '0, 64'hDEAD_BEEF_0123_4567));
    @(posedge clk); #1;
    cen   = 1'b0;
    rst_n = 1'b0;
    flush_sb();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d_midread_rdata", d + 1), rdata[d], '0);
      chk($sformatf("lat%0d_midread_valid", d + 1), {63'd0, rd_valid[d]}, '0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Array contents survive reset.
    apply(mk(OP_RD, 11'h005, '0, '0, 64'hDEAD_BEEF_0123_4567));
    idle(1);
    for (int i = 0; i < 20 && (sbq[0].size() + sbq[1].size()) > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", W'(sbq[0].size() + sbq[1].size()), '0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
